// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the mux scan controller.
// State encodings, default select width and word-width derivation.
package mux_scan_ctrl_pkg;

  localparam int SEL_W_DEF = 4;
  localparam int SETTLE_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_e;

  function automatic int word_w(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_settle_cnt.sv
// Settle-delay counter: counts wait cycles after each select step.
// Raises term when the count reaches SETTLE-1.
module scan_settle_cnt
  import mux_scan_ctrl_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam logic [SETTLE_W-1:0] LAST =
    SETTLE_W'(SETTLE - 1);

  logic [SETTLE_W-1:0] cnt_q;
  logic [SETTLE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == LAST);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a 2**SEL_W:1 mux one select at a time and assembles
// the sampled bits into a parallel word with valid/ready out.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int SEL_W  = SEL_W_DEF,
  parameter int SETTLE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [SEL_W-1:0]         sel,
  input  logic                     y_in,
  output logic [word_w(SEL_W)-1:0] data_out,
  output logic                     valid,
  input  logic                     ready,
  output logic                     busy
);

  localparam int N = word_w(SEL_W);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

  // With no settle delay every select step samples straight away
  localparam scan_state_e ST_STEP =
    (SETTLE > 0) ? ST_WAIT : ST_SAMPLE;

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic cnt_clr;
  logic cnt_en;
  logic settle_done;

  if (SETTLE > 0) begin : g_settle
    scan_settle_cnt #(
      .SETTLE(SETTLE)
    ) u_settle_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .term (settle_done)
    );
  end else begin : g_no_settle
    logic unused_cnt;
    assign unused_cnt  = cnt_clr ^ cnt_en;
    assign settle_done = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d   = '0;
          data_d  = '0;
          cnt_clr = 1'b1;
          state_d = ST_STEP;
        end
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        if (settle_done) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        data_d[sel_q] = y_in;
        cnt_clr       = 1'b1;
        if (sel_q == SEL_LAST) begin
          sel_d   = '0;
          state_d = ST_DONE;
        end else begin
          sel_d   = sel_q + 1'b1;
          state_d = ST_STEP;
        end
      end
      ST_DONE: begin
        if (ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_DONE);
    busy_d  = (state_d == ST_WAIT) ||
              (state_d == ST_SAMPLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign sel      = sel_q;
  assign data_out = data_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule
